// File: rtl/score_pkg.sv
// Shared types and constants for the score display: FSM state encoding,
// active-low 7-segment codes and the BCD-to-segment lookup helper.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_CMP  = 2'd2
  } state_e;

  // Active-low codes, bit7 = DP (kept off), bits6:0 = g..a
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] BLANK = 8'hFF;

  // Non-BCD codes cannot arise from the score registers; show them dark.
  function automatic logic [7:0] seg_code(input logic [3:0] bcd);
    logic [7:0] code;
    case (bcd)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/score_hex_display_seg7_decode.sv
// One display digit: BCD value plus blank request to active-low segment code.
module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [7:0] seg
);

  // Blank overrides the digit value
  always_comb begin
    if (blank) begin
      seg = BLANK;
    end else begin
      seg = seg_code(bcd);
    end
  end

endmodule

// File: rtl/score_hex_display.sv
// BCD score keeper with high-score tracking and a multi-digit 7-segment
// display. Additions ripple one digit per cycle, so the add latency is fixed
// at N_DIGITS+1 cycles regardless of the value added.
module score_hex_display
  import score_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  add_valid,
  input  logic [3:0]            add_amt,
  output logic                  add_ready,
  input  logic                  clear,
  input  logic                  hi_sel,
  output logic [4*N_DIGITS-1:0] score_bcd,
  output logic [4*N_DIGITS-1:0] hi_bcd,
  output logic                  new_hi,
  output logic [8*N_DIGITS-1:0] seg
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SW = 4 * N_DIGITS;

  localparam logic [SW-1:0] ALL_NINES  = {N_DIGITS{4'h9}};
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

  state_e                state_r;
  logic [SW-1:0]         score_r;
  logic [SW-1:0]         hi_r;
  logic                  new_hi_r;
  logic [3:0]            carry_r;
  logic [IW-1:0]         idx_r;
  logic [CW-1:0]         blink_cnt_r;
  logic                  phase_r;
  logic [8*N_DIGITS-1:0] seg_r;

  logic                  transfer_s;
  logic [3:0]            amt_clamped_s;
  logic [3:0]            cur_digit_s;
  logic [4:0]            sum_s;
  logic [3:0]            digit_next_s;
  logic [3:0]            carry_next_s;
  logic [SW-1:0]         score_add_s;
  logic [SW-1:0]         score_final_s;
  logic [SW-1:0]         src_s;
  logic                  blank_all_s;
  logic                  seen_nz_s;
  logic [N_DIGITS-1:0]   blank_vec_s;
  logic [8*N_DIGITS-1:0] dec_s;

  // clear blocks the handshake so a simultaneous add is never accepted
  assign add_ready     = (state_r == ST_IDLE) && !clear;
  assign transfer_s    = add_valid && add_ready;
  assign amt_clamped_s = (add_amt > 4'd9) ? 4'd9 : add_amt;

  // Single-digit BCD adder applied to the digit selected by idx_r
  always_comb begin
    cur_digit_s = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      cur_digit_s = (idx_r == IW'(i)) ? score_r[4*i +: 4] : cur_digit_s;
    end
    sum_s = {1'b0, cur_digit_s} + {1'b0, carry_r};
    if (sum_s >= 5'd10) begin
      digit_next_s = 4'(sum_s - 5'd10);
      carry_next_s = 4'd1;
    end else begin
      digit_next_s = sum_s[3:0];
      carry_next_s = 4'd0;
    end
    score_add_s = score_r;
    for (int i = 0; i < N_DIGITS; i++) begin
      score_add_s[4*i +: 4] = (idx_r == IW'(i)) ? digit_next_s : score_r[4*i +: 4];
    end
    // A carry left over from the top digit means overflow: pin at all nines
    score_final_s = (carry_r != 4'd0) ? ALL_NINES : score_r;
  end

  // Score FSM: accept, ripple digits, saturate/compare, return to idle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      score_r  <= {SW{1'b0}};
      hi_r     <= {SW{1'b0}};
      new_hi_r <= 1'b0;
      carry_r  <= 4'd0;
      idx_r    <= {IW{1'b0}};
    end else if (clear) begin
      state_r  <= ST_IDLE;
      score_r  <= {SW{1'b0}};
      new_hi_r <= 1'b0;
      carry_r  <= 4'd0;
      idx_r    <= {IW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (transfer_s) begin
            carry_r <= amt_clamped_s;
            idx_r   <= {IW{1'b0}};
            state_r <= ST_ADD;
          end
        end
        ST_ADD: begin
          score_r <= score_add_s;
          carry_r <= carry_next_s;
          if (idx_r == LAST_IDX) begin
            state_r <= ST_CMP;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        ST_CMP: begin
          score_r <= score_final_s;
          carry_r <= 4'd0;
          idx_r   <= {IW{1'b0}};
          // BCD digits order the same way as binary, so a plain compare works
          if (score_final_s > hi_r) begin
            hi_r     <= score_final_s;
            new_hi_r <= 1'b1;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Free-running blink timebase; phase toggles once per BLINK_DIV cycles
  always_ff @(posedge Clk) begin
    if (Reset) begin
      blink_cnt_r <= {CW{1'b0}};
      phase_r     <= 1'b1;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= {CW{1'b0}};
      phase_r     <= ~phase_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + CW'(1);
    end
  end

  assign src_s       = hi_sel ? hi_r : score_r;
  assign blank_all_s = new_hi_r && !hi_sel && !phase_r;

  // Leading-zero blanking scanned from the top digit; digit 0 always shows
  always_comb begin
    seen_nz_s   = 1'b0;
    blank_vec_s = {N_DIGITS{1'b0}};
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      seen_nz_s      = seen_nz_s | (src_s[4*i +: 4] != 4'd0);
      blank_vec_s[i] = blank_all_s | ((i != 0) && !seen_nz_s);
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .bcd   (src_s[4*g +: 4]),
      .blank (blank_vec_s[g]),
      .seg   (dec_s[8*g +: 8])
    );
  end

  // Register the display drive so the pins are glitch-free
  always_ff @(posedge Clk) begin
    if (Reset) begin
      seg_r <= {(8*N_DIGITS){1'b1}};
    end else begin
      seg_r <= dec_s;
    end
  end

  assign score_bcd = score_r;
  assign hi_bcd    = hi_r;
  assign new_hi    = new_hi_r;
  assign seg       = seg_r;

endmodule

// File: tb/tb_score_hex_display.sv
// Directed bench for score_hex_display with N_DIGITS=4, BLINK_DIV=4.
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_score_hex_display;

  logic        Clk;
  logic        Reset;
  logic        add_valid;
  logic [3:0]  add_amt;
  logic        add_ready;
  logic        clear;
  logic        hi_sel;
  logic [15:0] score_bcd;
  logic [15:0] hi_bcd;
  logic        new_hi;
  logic [31:0] seg;

  int checks   = 0;
  int failures = 0;

  score_hex_display #(.N_DIGITS(4), .BLINK_DIV(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .add_valid (add_valid),
    .add_amt   (add_amt),
    .add_ready (add_ready),
    .clear     (clear),
    .hi_sel    (hi_sel),
    .score_bcd (score_bcd),
    .hi_bcd    (hi_bcd),
    .new_hi    (new_hi),
    .seg       (seg)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge Clk);
  endtask

  // Perform one handshake and return how many samples add_ready stayed low
  task automatic do_add(input logic [3:0] amt, output int lat);
    int w;
    w = 0;
    while (add_ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    add_valid = 1'b1;
    add_amt   = amt;
    step();
    add_valid = 1'b0;
    add_amt   = 4'd0;
    lat = 0;
    while (add_ready !== 1'b1 && lat < 20) begin
      lat++;
      step();
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; add_valid = 1'b0; add_amt = 4'd0; clear = 1'b0; hi_sel = 1'b0;
    step();
    step();
    checks++; if (seg !== 32'hFFFFFFFF) begin failures++; $display("FAIL reset_seg got=%h exp=%h", seg, 32'hFFFFFFFF); end
    checks++; if (score_bcd !== 16'h0000) begin failures++; $display("FAIL reset_score got=%h exp=0000", score_bcd); end
    checks++; if (hi_bcd !== 16'h0000) begin failures++; $display("FAIL reset_hi got=%h exp=0000", hi_bcd); end
    checks++; if (new_hi !== 1'b0) begin failures++; $display("FAIL reset_new_hi got=%b exp=0", new_hi); end
    Reset = 1'b0;
    step();
    checks++; if (seg !== 32'hFFFFFFC0) begin failures++; $display("FAIL post_reset_seg got=%h exp=FFFFFFC0", seg); end
    checks++; if (add_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", add_ready); end
  endtask

  task automatic test_basic();
    int lat;
    do_add(4'd7, lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL basic_lat7 got=%0d exp=5", lat); end
    checks++; if (score_bcd !== 16'h0007) begin failures++; $display("FAIL basic_score7 got=%h exp=0007", score_bcd); end
    do_add(4'd5, lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL basic_lat5 got=%0d exp=5", lat); end
    checks++; if (score_bcd !== 16'h0012) begin failures++; $display("FAIL basic_score12 got=%h exp=0012", score_bcd); end
    checks++; if (hi_bcd !== 16'h0012) begin failures++; $display("FAIL basic_hi got=%h exp=0012", hi_bcd); end
    checks++; if (new_hi !== 1'b1) begin failures++; $display("FAIL basic_new_hi got=%b exp=1", new_hi); end
  endtask

  task automatic test_blink_select();
    logic is_blank [16];
    int bad;
    int j;
    bad = 0;
    hi_sel = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      is_blank[k] = (seg === 32'hFFFFFFFF);
      if (!is_blank[k] && seg !== 32'hFFFFF9A4) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL blink_values bad_samples=%0d exp=0 last_seg=%h", bad, seg); end
    j = 0;
    for (int k = 1; k <= 4; k++) begin
      if (j == 0 && is_blank[k] !== is_blank[k-1]) j = k;
    end
    checks++;
    if (j == 0) begin
      failures++;
      $display("FAIL blink_edge no phase change within 5 samples exp=change");
    end else begin
      for (int m = 1; m < 8; m++) begin
        logic exp_b;
        exp_b = (m < 4) ? is_blank[j] : !is_blank[j];
        checks++;
        if (is_blank[j+m] !== exp_b) begin
          failures++;
          $display("FAIL blink_run sample=%0d got_blank=%b exp_blank=%b", j+m, is_blank[j+m], exp_b);
        end
      end
    end
    hi_sel = 1'b1;
    step();
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (seg !== 32'hFFFFF9A4) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL hi_sel_steady bad_samples=%0d exp=0 last_seg=%h", bad, seg); end
    hi_sel = 1'b0;
  endtask

  task automatic test_clamp_ripple();
    int lat;
    int errs;
    pulse_clear();
    checks++; if (score_bcd !== 16'h0000) begin failures++; $display("FAIL clamp_clear got=%h exp=0000", score_bcd); end
    errs = 0;
    for (int k = 0; k < 111; k++) begin
      do_add(4'd9, lat);
      if (lat != 5) errs++;
    end
    checks++; if (errs != 0) begin failures++; $display("FAIL clamp_loop_lat bad=%0d exp=0", errs); end
    checks++; if (score_bcd !== 16'h0999) begin failures++; $display("FAIL clamp_score999 got=%h exp=0999", score_bcd); end
    do_add(4'd15, lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL clamp_lat got=%0d exp=5", lat); end
    checks++; if (score_bcd !== 16'h1008) begin failures++; $display("FAIL clamp_score got=%h exp=1008", score_bcd); end
    checks++; if (hi_bcd !== 16'h1008) begin failures++; $display("FAIL clamp_hi got=%h exp=1008", hi_bcd); end
    checks++; if (new_hi !== 1'b1) begin failures++; $display("FAIL clamp_new_hi got=%b exp=1", new_hi); end
  endtask

  task automatic test_clear();
    int w;
    w = 0;
    while (add_ready !== 1'b1 && w < 20) begin step(); w++; end
    add_valid = 1'b1; add_amt = 4'd5;
    step();
    add_valid = 1'b0; add_amt = 4'd0;
    step();
    clear = 1'b1;
    step();
    checks++; if (score_bcd !== 16'h0000) begin failures++; $display("FAIL clear_add_score got=%h exp=0000", score_bcd); end
    checks++; if (new_hi !== 1'b0) begin failures++; $display("FAIL clear_add_new_hi got=%b exp=0", new_hi); end
    checks++; if (hi_bcd !== 16'h1008) begin failures++; $display("FAIL clear_add_hi got=%h exp=1008", hi_bcd); end
    checks++; if (add_ready !== 1'b0) begin failures++; $display("FAIL clear_hold_ready got=%b exp=0", add_ready); end
    clear = 1'b0;
    #1;
    checks++; if (add_ready !== 1'b1) begin failures++; $display("FAIL clear_release_ready got=%b exp=1", add_ready); end
    step();
    checks++; if (score_bcd !== 16'h0000) begin failures++; $display("FAIL clear_no_resume got=%h exp=0000", score_bcd); end
    clear = 1'b1; add_valid = 1'b1; add_amt = 4'd3;
    #1;
    checks++; if (add_ready !== 1'b0) begin failures++; $display("FAIL clear_valid_ready got=%b exp=0", add_ready); end
    step();
    clear = 1'b0; add_valid = 1'b0; add_amt = 4'd0;
    #1;
    checks++; if (add_ready !== 1'b1) begin failures++; $display("FAIL clear_valid_no_xfer got=%b exp=1", add_ready); end
    for (int k = 0; k < 6; k++) step();
    checks++; if (score_bcd !== 16'h0000) begin failures++; $display("FAIL clear_valid_score got=%h exp=0000", score_bcd); end
    hi_sel = 1'b1;
    step();
    checks++; if (seg !== 32'hF9C0C080) begin failures++; $display("FAIL sel_hi_seg got=%h exp=F9C0C080", seg); end
    hi_sel = 1'b0;
    step();
    checks++; if (seg !== 32'hFFFFFFC0) begin failures++; $display("FAIL sel_score_seg got=%h exp=FFFFFFC0", seg); end
  endtask

  task automatic test_saturation();
    int lat;
    int errs;
    pulse_clear();
    errs = 0;
    for (int k = 0; k < 1110; k++) begin
      do_add(4'd9, lat);
      if (lat != 5) errs++;
    end
    do_add(4'd5, lat);
    checks++; if (errs != 0) begin failures++; $display("FAIL sat_loop_lat bad=%0d exp=0", errs); end
    checks++; if (score_bcd !== 16'h9995) begin failures++; $display("FAIL sat_score9995 got=%h exp=9995", score_bcd); end
    do_add(4'd9, lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL sat_lat got=%0d exp=5", lat); end
    checks++; if (score_bcd !== 16'h9999) begin failures++; $display("FAIL sat_score got=%h exp=9999", score_bcd); end
    checks++; if (hi_bcd !== 16'h9999) begin failures++; $display("FAIL sat_hi got=%h exp=9999", hi_bcd); end
    checks++; if (new_hi !== 1'b1) begin failures++; $display("FAIL sat_new_hi got=%b exp=1", new_hi); end
    do_add(4'd9, lat);
    checks++; if (score_bcd !== 16'h9999) begin failures++; $display("FAIL sat_again got=%h exp=9999", score_bcd); end
  endtask

  task automatic test_reset_in_cmp();
    int w;
    w = 0;
    while (add_ready !== 1'b1 && w < 20) begin step(); w++; end
    add_valid = 1'b1; add_amt = 4'd1;
    step();
    add_valid = 1'b0; add_amt = 4'd0;
    for (int k = 0; k < 4; k++) step();
    checks++; if (add_ready !== 1'b0) begin failures++; $display("FAIL cmp_busy got=%b exp=0", add_ready); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++; if (score_bcd !== 16'h0000) begin failures++; $display("FAIL rst_cmp_score got=%h exp=0000", score_bcd); end
    checks++; if (hi_bcd !== 16'h0000) begin failures++; $display("FAIL rst_cmp_hi got=%h exp=0000", hi_bcd); end
    checks++; if (new_hi !== 1'b0) begin failures++; $display("FAIL rst_cmp_new_hi got=%b exp=0", new_hi); end
    checks++; if (seg !== 32'hFFFFFFFF) begin failures++; $display("FAIL rst_cmp_seg got=%h exp=FFFFFFFF", seg); end
    checks++; if (add_ready !== 1'b1) begin failures++; $display("FAIL rst_cmp_ready got=%b exp=1", add_ready); end
    step();
    checks++; if (seg !== 32'hFFFFFFC0) begin failures++; $display("FAIL rst_cmp_seg_after got=%h exp=FFFFFFC0", seg); end
    checks++; if (score_bcd !== 16'h0000) begin failures++; $display("FAIL rst_cmp_no_partial got=%h exp=0000", score_bcd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blink_select();
    test_clamp_ripple();
    test_clear();
    test_saturation();
    test_reset_in_cmp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
